ram_24x8_loader: RTL

Writer-side counterpart to the 24x8 ROM built from 8x8 banks. The block holds a 24x8 memory organised as three 8x8 banks, selected by addr[4:3] with offset addr[2:0]. A sequential load engine accepts a burst of bytes over a valid/ready handshake and writes them at auto-incrementing addresses. The read side uses the same cs/addrb/datab/read_en interface as the ROM, so the block can stand in for it once loaded.

---
 rtl/ram_24x8_loader_if.sv | 31 +++
 rtl/ram_24x8_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_24x8_loader_if.sv
// Bus bundle for ram_24x8_loader: burst-load handshake, status flags and the ROM-style read port.
// state_dbg mirrors the loader FSM state (0=IDLE, 1=LOAD, 2=DONE) for observation.
interface ram_24x8_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic              cs;
    logic              read_en;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] datab;
    logic [1:0]        state_dbg;

    modport master (
        output start, base_addr, length, wr_valid, wr_data, cs, read_en, addrb,
        input  wr_ready, busy, done, err, datab, state_dbg
    );

    modport slave (
        input  start, base_addr, length, wr_valid, wr_data, cs, read_en, addrb,
        output wr_ready, busy, done, err, datab, state_dbg
    );
endinterface

// File: rtl/ram_24x8_loader.sv
// 24x8 RAM (three 8x8 banks) with a sequential burst loader and a ROM-compatible read port.
// Optional macro LOADER_READBACK_LOCK_EN: forces datab to 0 while the loader is busy.
module ram_24x8_loader #(
    parameter int DATA_W     = 8,
    parameter int BANK_DEPTH = 8,
    parameter int NUM_BANKS  = 3,
    parameter int ADDR_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_24x8_loader_if.slave     bus
);
    localparam int DEPTH = NUM_BANKS * BANK_DEPTH;
    localparam int OFF_W = $clog2(BANK_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] MAX_LEN   = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [NUM_BANKS][BANK_DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_BANKS][BANK_DEPTH];
    logic              xfer;
    logic              bad_req;
    logic [DATA_W-1:0] rd_data;

    // Handshake: a byte is taken on a rising edge where wr_valid && wr_ready;
    // wr_ready depends only on state, so the writer may hold wr_valid as long as it likes.
    assign xfer    = (state_q == S_LOAD) && bus.wr_valid;
    assign bad_req = (bus.base_addr > LAST_ADDR) || (bus.length == '0) || (bus.length > MAX_LEN);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = bus.base_addr;
                        cnt_d   = bus.length;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    // ptr never exceeds LAST_ADDR, so the bank index stays inside the array
                    mem_d[ptr_q[ADDR_W-1:OFF_W]][ptr_q[OFF_W-1:0]] = bus.wr_data;
                    cnt_d = cnt_q - 1'b1;
                    ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int o = 0; o < BANK_DEPTH; o++) begin
                    mem_q[b][o] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    // Asynchronous read: a same-cycle write shows up only after the edge
    always_comb begin
        rd_data = '0;
        if (bus.cs && bus.read_en && (bus.addrb <= LAST_ADDR)) begin
            rd_data = mem_q[bus.addrb[ADDR_W-1:OFF_W]][bus.addrb[OFF_W-1:0]];
        end
    end

    assign bus.wr_ready  = (state_q == S_LOAD);
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

`ifdef LOADER_READBACK_LOCK_EN
    assign bus.datab = bus.busy ? '0 : rd_data;
`else
    assign bus.datab = rd_data;
`endif

endmodule
